// File: rtl/tracker_pkg.sv
// Shared state encoding and servo direction codes for the sweep peak tracker.
// Output decode helpers keep the FSM's registered outputs in one place.
package tracker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_PARK,
        ST_HOLD,
        ST_FAULT
    } state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_CW   = 2'b01;
    localparam logic [1:0] DIR_CCW  = 2'b10;

    function automatic logic [1:0] state_dir(input state_t s);
        logic [1:0] d;
        d = DIR_STOP;
        unique case (s)
            ST_SWEEP:         d = DIR_CW;
            ST_PARK, ST_HOLD: d = DIR_CCW;
            default:          d = DIR_STOP;
        endcase
        return d;
    endfunction

    function automatic logic state_en(input state_t s);
        return (s == ST_SWEEP) || (s == ST_PARK) || (s == ST_HOLD);
    endfunction

    function automatic logic state_max_en(input state_t s);
        return (s == ST_PARK) || (s == ST_HOLD);
    endfunction

    function automatic logic state_busy(input state_t s);
        return (s == ST_SWEEP) || (s == ST_PARK);
    endfunction

endpackage

// File: rtl/peak_detector.sv
// Tracks the strongest ADC reading seen during a sweep and the pulse width
// at which it occurred; later readings must beat the best by more than HYST.
import tracker_pkg::*;

module peak_detector #(
    parameter int ADC_W  = 12,
    parameter int MIN_PW = 50,
    parameter int HYST   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_sample_en,
    input  logic [ADC_W-1:0] i_adc_data,
    input  logic [31:0]      i_pulse_width,
    output logic [ADC_W-1:0] o_best_value,
    output logic [31:0]      o_position,
    output logic             o_peak_valid
);

    logic [ADC_W-1:0] r_best;
    logic [31:0]      r_pos;
    logic             r_valid;
    logic [ADC_W:0]   w_thresh;
    logic             w_better;

    // One extra bit so best+HYST near full scale cannot wrap and re-accept.
    assign w_thresh = {1'b0, r_best} + (ADC_W+1)'(HYST);
    assign w_better = !r_valid || ({1'b0, i_adc_data} > w_thresh);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_best  <= '0;
            r_pos   <= 32'(MIN_PW);
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_sample_en && w_better) begin
            r_best  <= i_adc_data;
            r_pos   <= i_pulse_width;
            r_valid <= 1'b1;
        end
    end

    assign o_best_value = r_best;
    assign o_position   = r_pos;
    assign o_peak_valid = r_valid;

endmodule

// File: rtl/sweep_peak_tracker.sv
// Commands one CW servo sweep, records the brightest position, then parks
// the PWM stage there; includes settle and sweep-timeout supervision.
import tracker_pkg::*;

module sweep_peak_tracker #(
    parameter int ADC_W          = 12,
    parameter int MIN_PW         = 50,
    parameter int MAX_PW         = 250,
    parameter int HYST           = 4,
    parameter int SETTLE_CYCLES  = 50000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             STOP,
    input  logic [ADC_W-1:0] ADC_DATA,
    input  logic             ADC_VALID,
    input  logic [31:0]      pulseWidth,
    output logic [1:0]       DIR,
    output logic             EN,
    output logic             max_enable,
    output logic [31:0]      pulseWidth_max,
    output logic [ADC_W-1:0] best_value,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_restart;
    logic [TO_W-1:0] r_to_cnt;
    logic [ST_W-1:0] r_settle;
    logic [1:0]      r_dir;
    logic            r_en;
    logic            r_max_en;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_end;
    logic            w_to_hit;
    logic            w_settle_hit;
    logic            w_clear;
    logic            w_sample;
    logic            w_peak_valid;

    assign w_end        = pulseWidth >= 32'(MAX_PW);
    assign w_to_hit     = r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
    assign w_settle_hit = r_settle == ST_W'(SETTLE_CYCLES - 1);
    assign w_clear      = (w_next == ST_SWEEP) && (r_state != ST_SWEEP);
    assign w_sample     = (r_state == ST_SWEEP) && ADC_VALID && !STOP;

    always_comb begin
        w_next = r_state;
        if (STOP) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (START || r_restart) w_next = ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (w_end)         w_next = ST_PARK;
                    else if (w_to_hit) w_next = ST_FAULT;
                end
                ST_PARK: begin
                    if (w_settle_hit) w_next = ST_HOLD;
                end
                ST_HOLD, ST_FAULT: begin
                    if (START) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_restart <= 1'b0;
            r_to_cnt  <= '0;
            r_settle  <= '0;
            r_dir     <= DIR_STOP;
            r_en      <= 1'b0;
            r_max_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_dir    <= state_dir(w_next);
            r_en     <= state_en(w_next);
            r_max_en <= state_max_en(w_next);
            r_busy   <= state_busy(w_next);
            r_err    <= (w_next == ST_FAULT);
            r_done   <= (r_state == ST_PARK) && (w_next == ST_HOLD);
            // Remember a HOLD/FAULT restart so a one-cycle START still sweeps.
            r_restart <= !STOP && START &&
                         ((r_state == ST_HOLD) || (r_state == ST_FAULT));
            if ((r_state == ST_SWEEP) && (w_next == ST_SWEEP))
                r_to_cnt <= r_to_cnt + TO_W'(1);
            else
                r_to_cnt <= '0;
            if ((r_state == ST_PARK) && (w_next == ST_PARK))
                r_settle <= r_settle + ST_W'(1);
            else
                r_settle <= '0;
        end
    end

    peak_detector #(
        .ADC_W  (ADC_W),
        .MIN_PW (MIN_PW),
        .HYST   (HYST)
    ) u_peak (
        .i_clk         (CLK),
        .i_rst_n       (RST_N),
        .i_clear       (w_clear),
        .i_sample_en   (w_sample),
        .i_adc_data    (ADC_DATA),
        .i_pulse_width (pulseWidth),
        .o_best_value  (best_value),
        .o_position    (pulseWidth_max),
        .o_peak_valid  (w_peak_valid)
    );

    assign DIR        = r_dir;
    assign EN         = r_en;
    assign max_enable = r_max_en;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign ERR        = r_err;

endmodule

// File: tb/tb_sweep_peak_tracker.sv
// Directed bench for sweep_peak_tracker with short settle/timeout counts.
module tb_sweep_peak_tracker;

    localparam int ADC_W = 12;
    localparam int SETTLE = 20;
    localparam int TMO = 1000;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic [ADC_W-1:0] ADC_DATA = '0;
    logic             ADC_VALID = 1'b0;
    logic [31:0]      pulseWidth = 32'd50;
    logic [1:0]       DIR;
    logic             EN;
    logic             max_enable;
    logic [31:0]      pulseWidth_max;
    logic [ADC_W-1:0] best_value;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    int n_chk = 0;
    int n_err = 0;

    sweep_peak_tracker #(
        .ADC_W          (ADC_W),
        .MIN_PW         (50),
        .MAX_PW         (250),
        .HYST           (4),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .START          (START),
        .STOP           (STOP),
        .ADC_DATA       (ADC_DATA),
        .ADC_VALID      (ADC_VALID),
        .pulseWidth     (pulseWidth),
        .DIR            (DIR),
        .EN             (EN),
        .max_enable     (max_enable),
        .pulseWidth_max (pulseWidth_max),
        .best_value     (best_value),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .ERR            (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input int pw, input int val);
        pulseWidth = 32'(pw);
        ADC_DATA = ADC_W'(val);
        ADC_VALID = 1'b1;
        tick();
        ADC_VALID = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_pwmax", pulseWidth_max, 50);
        chk("rst_best", best_value, 0);
        chk("rst_en", EN, 0);
        chk("rst_dir", DIR, 0);
        chk("rst_maxen", max_enable, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        RST_N = 1'b1;
        tick();

        // Peak location sweep 50..250 with peak 3000 at 120
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("sw_en", EN, 1);
        chk("sw_dir", DIR, 1);
        chk("sw_busy", BUSY, 1);
        chk("sw_maxen", max_enable, 0);
        for (int p = 50; p < 250; p++)
            sample(p, (p == 120) ? 3000 : (p % 7) * 250);
        chk("sw_still_dir", DIR, 1);
        sample(250, 100);
        chk("park_dir", DIR, 2);
        chk("park_maxen", max_enable, 1);
        chk("park_busy", BUSY, 1);
        chk("park_pwmax", pulseWidth_max, 120);
        chk("park_best", best_value, 3000);
        repeat (SETTLE - 1) tick();
        chk("park_nodone", DONE, 0);
        tick();
        chk("hold_done", DONE, 1);
        chk("hold_dir", DIR, 2);
        chk("hold_maxen", max_enable, 1);
        chk("hold_en", EN, 1);
        chk("hold_busy", BUSY, 0);
        tick();
        chk("hold_done_pulse", DONE, 0);

        // Restart from HOLD with a one-cycle START
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("rs_idle_en", EN, 0);
        chk("rs_idle_dir", DIR, 0);
        tick();
        chk("rs_sw_en", EN, 1);
        chk("rs_sw_dir", DIR, 1);

        // Hysteresis; first sample lower than old best proves peak_valid cleared
        sample(60, 1000);
        chk("hy_first_best", best_value, 1000);
        chk("hy_first_pw", pulseWidth_max, 60);
        sample(70, 1003);
        chk("hy_1003_pw", pulseWidth_max, 60);
        sample(80, 1005);
        chk("hy_1005_pw", pulseWidth_max, 80);
        chk("hy_1005_best", best_value, 1005);
        sample(90, 1009);
        chk("hy_eq_pw", pulseWidth_max, 80);

        // STOP and START together mid-sweep, with a sample in the same cycle
        START = 1'b1;
        STOP = 1'b1;
        sample(100, 4000);
        START = 1'b0;
        STOP = 1'b0;
        chk("stop_en", EN, 0);
        chk("stop_dir", DIR, 0);
        chk("stop_busy", BUSY, 0);
        chk("stop_done", DONE, 0);
        chk("stop_best", best_value, 1005);
        chk("stop_pwmax", pulseWidth_max, 80);
        sample(110, 4000);
        chk("idle_adc_ign", best_value, 1005);
        chk("idle_stays", EN, 0);

        // Timeout with pulseWidth stuck at 100
        pulseWidth = 32'd100;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (TMO - 1) tick();
        chk("to_before_err", ERR, 0);
        chk("to_before_en", EN, 1);
        tick();
        chk("to_err", ERR, 1);
        chk("to_en", EN, 0);
        chk("to_dir", DIR, 0);
        chk("to_busy", BUSY, 0);
        chk("to_pwmax", pulseWidth_max, 80);
        tick();
        chk("to_sticky", ERR, 1);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("to_clr_err", ERR, 0);
        chk("to_clr_en", EN, 0);
        tick();
        chk("to_rs_en", EN, 1);
        chk("to_rs_dir", DIR, 1);

        // Asynchronous reset mid-sweep
        sample(150, 2500);
        chk("mr_best", best_value, 2500);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mr_pwmax", pulseWidth_max, 50);
        chk("mr_best0", best_value, 0);
        chk("mr_en", EN, 0);
        chk("mr_dir", DIR, 0);
        chk("mr_busy", BUSY, 0);
        tick();
        RST_N = 1'b1;
        tick();
        chk("mr_idle", EN, 0);

        // Sweep with no valid sample keeps MIN_PW
        START = 1'b1;
        pulseWidth = 32'd50;
        tick();
        START = 1'b0;
        pulseWidth = 32'd250;
        tick();
        chk("ns_maxen", max_enable, 1);
        chk("ns_pwmax", pulseWidth_max, 50);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("ns_stop_en", EN, 0);
        chk("ns_stop_done", DONE, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
